lfsr_checker: RTL and testbench
===============================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 3: consecutive matching samples after the seed that are required to declare lock.
REQ-002 SHALL have parameter LOSS_CNT, default 2: consecutive mismatching samples while locked that force loss of lock.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port en, input, 1 bit: q_in holds a valid sample this cycle.
REQ-006 SHALL have port q_in, input, [3:1]: received 3-bit LFSR state.
REQ-007 SHALL have port clr_cnt, input, 1 bit: synchronous clear of err_cnt.
REQ-008 SHALL have port locked, output, 1 bit, registered: checker is in the LOCKED state.
REQ-009 SHALL have port err, output, 1 bit, registered: one-cycle pulse for a mismatch while locked.
REQ-010 SHALL have port err_cnt, output, [7:0], registered: saturating count of mismatches.

Function
REQ-011 SHALL define next(s) = {s[2], s[1], s[3]^s[2]} (polynomial x^3+x^2+1, period 7): 001->010->101->011->111->110->100->001.
REQ-012 SHALL treat q_in=000 as illegal, because it is the lockup state.
REQ-013 SHALL implement states HUNT, VERIFY and LOCKED, plus a 3-bit prediction register pred, a match counter and a miss counter.
REQ-014 SHALL, when en=0, hold all state, pred and counters, and drive err=0.
REQ-015 SHALL, in HUNT with en=1 and q_in!=000, load pred=next(q_in), clear the match counter and go to VERIFY; with q_in=000 it stays in HUNT.
REQ-016 SHALL, in VERIFY with en=1 and q_in==pred, increment the match counter and load pred=next(q_in); when the counter reaches LOCK_CNT it goes to LOCKED.
REQ-017 SHALL, in VERIFY with en=1 and q_in!=pred, reseed (pred=next(q_in), match counter=0) if q_in!=000, otherwise return to HUNT; err is not asserted in VERIFY.
REQ-018 SHALL, in LOCKED with en=1, flywheel pred=next(pred) regardless of q_in.
REQ-019 SHALL, in LOCKED on a match, clear the miss counter.
REQ-020 SHALL, in LOCKED on a mismatch (including q_in=000), pulse err, increment err_cnt and increment the miss counter; reaching LOSS_CNT moves the FSM to HUNT.
REQ-021 SHALL assert locked exactly while the state is LOCKED, i.e. one cycle after the LOCK_CNT-th matching sample and deasserting one cycle after the LOSS_CNT-th consecutive mismatch.
REQ-022 SHALL assert err on the cycle after the mismatching sample, for one cycle per mismatch.
REQ-023 SHALL saturate err_cnt at 255 (no wrap).
REQ-024 SHALL give clr_cnt priority over a simultaneous increment: err_cnt becomes 0.
REQ-025 SHALL have no effect on the state machine from clr_cnt.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, set state=HUNT, pred=000, both counters=0, locked=0, err=0 and err_cnt=0.
REQ-027 SHALL give reset priority over en and clr_cnt.
REQ-028 SHALL, when reset is applied mid-lock, drop locked on the next edge and require a full reacquisition afterwards.

Structure
REQ-029 SHALL place in a shared package lfsr_pkg: the width constant LFSR_W=3, the next-state function lfsr_next and the state enum (HUNT, VERIFY, LOCKED).
REQ-030 SHALL be implemented as a single module with no sub-module, with the FSM, counters and comparison in one clocked process plus next-state logic.

Verification
REQ-031 SHALL verify clean lock: reset, then en=1 with q_in = 001,010,101,011,111 -> locked=1 on the cycle after the sample 011; err never asserted; err_cnt=0.
REQ-032 SHALL verify a single error while locked: after lock, inject 100 where 110 is expected -> err pulses once, err_cnt=1, locked stays 1; the next sample 100 matches via flywheel, with no further err.
REQ-033 SHALL verify loss of lock: while locked, send two consecutive wrong samples (000, 000) -> two err pulses, err_cnt=2, locked=0 after the second; a restarted sequence relocks after 1+3 samples.
REQ-034 SHALL verify hunting: q_in=000 held for 5 cycles -> state stays HUNT, locked=0, err=0; then the sequence 100,001,010 followed by the mismatch 111 -> VERIFY reseeds without err.
REQ-035 SHALL verify saturation and clear: force 300 mismatches with lock maintained by alternating match/miss -> err_cnt=255; clr_cnt coinciding with a mismatch -> err_cnt=0.
REQ-036 SHALL verify reset mid-operation and en gaps: with en toggling 1/0 every cycle, lock still occurs after 4 valid samples; rst_n=0 for one cycle while locked -> locked=0, err_cnt=0 next cycle.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared width, state encoding and next-state function for the 3-bit LFSR checker
// Holds LFSR_W, the checker state enum and lfsr_next (x^3+x^2+1, period 7).
package lfsr_pkg;
    localparam int LFSR_W = 3;
    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
    function automatic logic [LFSR_W:1] lfsr_next(input logic [LFSR_W:1] s);
        return {s[2], s[1], s[3] ^ s[2]};
    endfunction
endpackage

// File: rtl/lfsr_checker.sv
// lfsr_checker: acquires lock on a received 3-bit LFSR sequence and counts mismatches while locked
// Ports: clk, rst_n (sync active-low), en (q_in valid), q_in (received state), clr_cnt (clear err_cnt);
//        locked (in LOCKED), err (one-cycle mismatch pulse), err_cnt (saturating mismatch count).
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [LFSR_W:1] q_in,
    input  logic            clr_cnt,
    output logic            locked,
    output logic            err,
    output logic [7:0]      err_cnt
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);
    state_t          state, state_nxt;
    logic [LFSR_W:1] pred;
    logic [MW-1:0]   match_cnt;
    logic [LW-1:0]   miss_cnt;
    logic            hit, nz, lock_hit, loss_hit, miss;
    assign hit      = q_in == pred;
    assign nz       = q_in != '0;
    assign lock_hit = match_cnt == MW'(LOCK_CNT - 1);
    assign loss_hit = miss_cnt == LW'(LOSS_CNT - 1);
    assign miss     = en && state == LOCKED && !hit;
    always_comb begin
        state_nxt = state;
        if (en)
            case (state)
                HUNT:    state_nxt = nz ? VERIFY : HUNT;
                VERIFY:  state_nxt = hit ? (lock_hit ? LOCKED : VERIFY) : (nz ? VERIFY : HUNT);
                LOCKED:  state_nxt = (!hit && loss_hit) ? HUNT : LOCKED;
                default: state_nxt = HUNT;
            endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HUNT;
            pred      <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state   <= state_nxt;
            locked  <= state_nxt == LOCKED;
            err     <= miss;
            err_cnt <= clr_cnt ? '0 : (miss && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
            if (en)
                case (state)
                    HUNT: if (nz) begin
                        pred      <= lfsr_next(q_in);
                        match_cnt <= '0;
                    end
                    VERIFY: begin
                        // a nonzero mismatch reseeds from the received value
                        pred      <= lfsr_next(q_in);
                        match_cnt <= hit ? match_cnt + 1'b1 : '0;
                    end
                    LOCKED: begin
                        // flywheel: prediction advances independently of q_in
                        pred     <= lfsr_next(pred);
                        miss_cnt <= (hit || loss_hit) ? '0 : miss_cnt + 1'b1;
                    end
                    default: pred <= '0;
                endcase
        end
    end
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed scoreboard bench for lfsr_checker
module tb_lfsr_checker;
    typedef struct packed {
        logic       l;
        logic       e;
        logic [7:0] c;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:1] q_in = 3'b000;
    logic       clr_cnt = 1'b0;
    logic       locked, err;
    logic [7:0] err_cnt;
    exp_t       exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [3:1] tp;

    lfsr_checker dut (
        .clk(clk), .rst_n(rst_n), .en(en), .q_in(q_in), .clr_cnt(clr_cnt),
        .locked(locked), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [3:1] nx(input logic [3:1] s);
        return {s[2], s[1], s[3] ^ s[2]};
    endfunction

    task automatic step(input string tag, input logic e, input logic [3:1] q, input logic c,
                        input logic xl, input logic xe, input int xc);
        exp_t x;
        en = e;
        q_in = q;
        clr_cnt = c;
        exp_q.push_back('{xl, xe, xc[7:0]});
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        vectors++;
        assert (locked === x.l) else begin
            miscompares++;
            $error("FAIL %s locked: got %b want %b", tag, locked, x.l);
        end
        assert (err === x.e) else begin
            miscompares++;
            $error("FAIL %s err: got %b want %b", tag, err, x.e);
        end
        assert (err_cnt === x.c) else begin
            miscompares++;
            $error("FAIL %s err_cnt: got %0d want %0d", tag, err_cnt, x.c);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        rst_n = 1'b0;
        step("reset", 1, 3'b001, 1, 0, 0, 0);
        rst_n = 1'b1;
        // clean lock
        step("lock_seed", 1, 3'b001, 0, 0, 0, 0);
        step("lock_m1", 1, 3'b010, 0, 0, 0, 0);
        step("lock_m2", 1, 3'b101, 0, 0, 0, 0);
        step("lock_m3", 1, 3'b011, 0, 1, 0, 0);
        step("lock_hold", 1, 3'b111, 0, 1, 0, 0);
        // single error while locked, flywheel realigns
        step("single_err", 1, 3'b100, 0, 1, 1, 1);
        step("flywheel", 1, 3'b100, 0, 1, 0, 1);
        // clear with en=0: FSM untouched
        step("clr_idle", 0, 3'b000, 1, 1, 0, 0);
        // loss of lock
        step("loss_1", 1, 3'b000, 0, 1, 1, 1);
        step("loss_2", 1, 3'b000, 0, 0, 1, 2);
        step("relock_seed", 1, 3'b001, 0, 0, 0, 2);
        step("relock_m1", 1, 3'b010, 0, 0, 0, 2);
        step("relock_m2", 1, 3'b101, 0, 0, 0, 2);
        step("relock_m3", 1, 3'b011, 0, 1, 0, 2);
        // en=0 holds pred
        step("en_gap", 0, 3'b000, 0, 1, 0, 2);
        step("en_resume", 1, 3'b111, 0, 1, 0, 2);
        // hunting on 000, then reseed in VERIFY
        rst_n = 1'b0;
        step("reset2", 1, 3'b110, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step("hunt_zero", 1, 3'b000, 0, 0, 0, 0);
        step("hunt_seed", 1, 3'b100, 0, 0, 0, 0);
        step("hunt_m1", 1, 3'b001, 0, 0, 0, 0);
        step("hunt_m2", 1, 3'b010, 0, 0, 0, 0);
        step("reseed", 1, 3'b111, 0, 0, 0, 0);
        step("reseed_m1", 1, 3'b110, 0, 0, 0, 0);
        step("reseed_m2", 1, 3'b100, 0, 0, 0, 0);
        step("reseed_m3", 1, 3'b001, 0, 1, 0, 0);
        // saturation with alternating miss/match
        tp = nx(3'b001);
        for (int k = 1; k <= 300; k++) begin
            step("sat_miss", 1, 3'b000, 0, 1, 1, (k > 255) ? 255 : k);
            tp = nx(tp);
            step("sat_match", 1, tp, 0, 1, 0, (k > 255) ? 255 : k);
            tp = nx(tp);
        end
        step("clr_on_miss", 1, 3'b000, 1, 1, 1, 0);
        tp = nx(tp);
        step("after_clr", 1, tp, 0, 1, 0, 0);
        // en toggling and reset mid-lock
        rst_n = 1'b0;
        step("reset3", 0, 3'b000, 0, 0, 0, 0);
        rst_n = 1'b1;
        step("tog_seed", 1, 3'b001, 0, 0, 0, 0);
        step("tog_gap1", 0, 3'b111, 0, 0, 0, 0);
        step("tog_m1", 1, 3'b010, 0, 0, 0, 0);
        step("tog_gap2", 0, 3'b000, 0, 0, 0, 0);
        step("tog_m2", 1, 3'b101, 0, 0, 0, 0);
        step("tog_gap3", 0, 3'b110, 0, 0, 0, 0);
        step("tog_m3", 1, 3'b011, 0, 1, 0, 0);
        step("tog_gap4", 0, 3'b000, 0, 1, 0, 0);
        step("pre_rst_miss", 1, 3'b000, 0, 1, 1, 1);
        rst_n = 1'b0;
        step("rst_mid_lock", 1, 3'b110, 1, 0, 0, 0);
        rst_n = 1'b1;
        step("post_rst", 1, 3'b100, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
